// File: rtl/aes_pkg.sv
// Shared AES definitions: S-box table, GF(2^8) xtime, key-schedule FSM states.
package aes_pkg;

    localparam int NB = 4;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        EXPAND,
        DONE
    } kexp_state_e;

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    // Multiply by x in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

endpackage

// File: rtl/aes_sbox_word.sv
// Four parallel S-box lookups on a 32-bit word; purely combinational.
module aes_sbox_word
    import aes_pkg::*;
(
    input  logic [31:0] word_i,
    output logic [31:0] word_o
);

    always_comb begin
        for (int b = 0; b < 4; b++) begin
            word_o[8*b +: 8] = SBOX[word_i[8*b +: 8]];
        end
    end

endmodule

// File: rtl/aes_key_expand_seq.sv
// Sequential AES key schedule: one 32-bit word per clock, all round keys on a flat bus.
// Optional AES_KEYEXP_ZEROIZE_EN adds a zeroize input that wipes keys and returns to IDLE.
module aes_key_expand_seq
    import aes_pkg::*;
#(
    parameter int NK = 4,
    parameter int NR = 10
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [32*NK-1:0]        key_in,
`ifdef AES_KEYEXP_ZEROIZE_EN
    input  logic                    zeroize,
`endif
    output logic                    busy,
    output logic                    done,
    output logic                    keys_valid,
    output logic [128*(NR+1)-1:0]   round_keys
);

    localparam int NW = NB * (NR + 1);
    localparam int IW = $clog2(NW + 1);

    kexp_state_e       state_q, state_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [2:0]        phase_q, phase_d;
    logic [7:0]        rcon_q, rcon_d;
    logic              done_q, done_d;
    logic              valid_q, valid_d;
    logic [32*NK-1:0]  key_q;
    logic [31:0]       w_q [NW];

    logic              key_load, word_load, word_wr, wipe;
    logic [31:0]       prev_w, back_w, sbox_in, sbox_out, temp_w, new_w;

`ifdef AES_KEYEXP_ZEROIZE_EN
    assign wipe = zeroize;
`else
    assign wipe = 1'b0;
`endif

    // NOTE: every signal written here gets a default first, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        phase_d   = phase_q;
        rcon_d    = rcon_q;
        done_d    = 1'b0;
        valid_d   = valid_q;
        key_load  = 1'b0;
        word_load = 1'b0;
        word_wr   = 1'b0;

        if (wipe) begin
            state_d = IDLE;
            idx_d   = '0;
            phase_d = '0;
            rcon_d  = '0;
            valid_d = 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        state_d  = LOAD;
                        key_load = 1'b1;
                        valid_d  = 1'b0;
                    end
                end
                LOAD: begin
                    word_load = 1'b1;
                    idx_d     = IW'(NK);
                    phase_d   = '0;
                    rcon_d    = 8'h01;
                    state_d   = EXPAND;
                end
                EXPAND: begin
                    word_wr = 1'b1;
                    idx_d   = idx_q + IW'(1);
                    phase_d = (phase_q == 3'(NK - 1)) ? 3'd0 : phase_q + 3'd1;
                    if (phase_q == 3'd0) begin
                        rcon_d = xtime(rcon_q);
                    end
                    if (idx_q == IW'(NW - 1)) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                        valid_d = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // phase_q tracks i mod NK, so the rotate/rcon step lands where phase wraps to zero.
    assign prev_w  = w_q[idx_q - IW'(1)];
    assign back_w  = w_q[idx_q - IW'(NK)];
    assign sbox_in = (phase_q == 3'd0) ? {prev_w[23:0], prev_w[31:24]} : prev_w;

    aes_sbox_word u_sbox (
        .word_i (sbox_in),
        .word_o (sbox_out)
    );

    always_comb begin
        if (phase_q == 3'd0) begin
            temp_w = sbox_out ^ {rcon_q, 24'h0};
        end else if (NK == 8 && phase_q == 3'd4) begin
            temp_w = sbox_out;
        end else begin
            temp_w = prev_w;
        end
        new_w = back_w ^ temp_w;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            phase_q <= '0;
            rcon_q  <= '0;
            done_q  <= 1'b0;
            valid_q <= 1'b0;
            key_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            phase_q <= phase_d;
            rcon_q  <= rcon_d;
            done_q  <= done_d;
            valid_q <= valid_d;
            if (wipe) begin
                key_q <= '0;
            end else if (key_load) begin
                key_q <= key_in;
            end
        end
    end

    // NOTE: the word array is reset on purpose; round_keys must read zero immediately after rst_n.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int j = 0; j < NW; j++) w_q[j] <= '0;
        end else if (wipe) begin
            for (int j = 0; j < NW; j++) w_q[j] <= '0;
        end else if (word_load) begin
            for (int j = 0; j < NK; j++) w_q[j] <= key_q[32*(NK-1-j) +: 32];
        end else if (word_wr) begin
            w_q[idx_q] <= new_w;
        end
    end

    // Word j belongs to round j/4; the first word of a round sits in its top 32 bits.
    for (genvar j = 0; j < NW; j++) begin : g_map
        assign round_keys[128*(j/4) + 32*(3 - (j % 4)) +: 32] = w_q[j];
    end

    assign busy       = (state_q == LOAD) || (state_q == EXPAND);
    assign done       = done_q;
    assign keys_valid = valid_q;

endmodule

// File: tb/tb_aes_key_expand_seq.sv
// Self-checking bench: AES-128/192/256 instances checked against a GF(2^8)-derived key-schedule model.
module tb_aes_key_expand_seq;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic           start128 = 1'b0, start192 = 1'b0, start256 = 1'b0;
    logic [127:0]   key128 = '0;
    logic [191:0]   key192 = '0;
    logic [255:0]   key256 = '0;
    logic           busy128, busy192, busy256;
    logic           done128, done192, done256;
    logic           kv128, kv192, kv256;
    logic [1407:0]  rk128;
    logic [1663:0]  rk192;
    logic [1919:0]  rk256;
`ifdef AES_KEYEXP_ZEROIZE_EN
    logic           zeroize128 = 1'b0;
`endif

    aes_key_expand_seq #(.NK(4), .NR(10)) u128 (
        .clk(clk), .rst_n(rst_n), .start(start128), .key_in(key128),
`ifdef AES_KEYEXP_ZEROIZE_EN
        .zeroize(zeroize128),
`endif
        .busy(busy128), .done(done128), .keys_valid(kv128), .round_keys(rk128));

    aes_key_expand_seq #(.NK(6), .NR(12)) u192 (
        .clk(clk), .rst_n(rst_n), .start(start192), .key_in(key192),
`ifdef AES_KEYEXP_ZEROIZE_EN
        .zeroize(1'b0),
`endif
        .busy(busy192), .done(done192), .keys_valid(kv192), .round_keys(rk192));

    aes_key_expand_seq #(.NK(8), .NR(14)) u256 (
        .clk(clk), .rst_n(rst_n), .start(start256), .key_in(key256),
`ifdef AES_KEYEXP_ZEROIZE_EN
        .zeroize(1'b0),
`endif
        .busy(busy256), .done(done256), .keys_valid(kv256), .round_keys(rk256));

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [7:0]  ref_tab [256];
    logic [31:0] mw [60];

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        logic [7:0] y = b;
        for (int k = 0; k < 8; k++) begin
            if (y[0]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
            y = y >> 1;
        end
        return p;
    endfunction

    // S-box from its definition: multiplicative inverse followed by the affine map.
    function automatic logic [7:0] sbox_def(input logic [7:0] a);
        logic [7:0] inv = 8'h01;
        if (a == 8'h00) inv = 8'h00;
        else for (int k = 0; k < 254; k++) inv = gmul(inv, a);
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
               {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] v);
        return {ref_tab[v[31:24]], ref_tab[v[23:16]], ref_tab[v[15:8]], ref_tab[v[7:0]]};
    endfunction

    function automatic void ref_expand(input int nk, input logic [255:0] key);
        int nw = 4 * (nk + 7);
        int rc = 1;
        logic [31:0] t;
        for (int j = 0; j < nk; j++) mw[j] = key[32*(nk-1-j) +: 32];
        for (int i = nk; i < nw; i++) begin
            t = mw[i-1];
            if (i % nk == 0) begin
                t = sub_word({t[23:0], t[31:24]}) ^ (32'(rc) << 24);
                rc = (rc * 2 >= 256) ? ((rc * 2) ^ 'h11b) : rc * 2;
            end else if (nk > 6 && i % nk == 4) begin
                t = sub_word(t);
            end
            mw[i] = mw[i-nk] ^ t;
        end
    endfunction

    // ---------------- DUT accessors ----------------
    function automatic logic [127:0] dut_round(input int nk, input int r);
        case (nk)
            4:       return rk128[128*r +: 128];
            6:       return rk192[128*r +: 128];
            default: return rk256[128*r +: 128];
        endcase
    endfunction

    function automatic logic dut_any(input int nk);
        case (nk)
            4:       return |rk128;
            6:       return |rk192;
            default: return |rk256;
        endcase
    endfunction

    function automatic logic dut_busy(input int nk);
        case (nk)
            4:       return busy128;
            6:       return busy192;
            default: return busy256;
        endcase
    endfunction

    function automatic logic dut_done(input int nk);
        case (nk)
            4:       return done128;
            6:       return done192;
            default: return done256;
        endcase
    endfunction

    function automatic logic dut_kv(input int nk);
        case (nk)
            4:       return kv128;
            6:       return kv192;
            default: return kv256;
        endcase
    endfunction

    task automatic drive_start(input int nk, input logic v, input logic [255:0] key);
        case (nk)
            4:       begin start128 = v; key128 = key[127:0]; end
            6:       begin start192 = v; key192 = key[191:0]; end
            default: begin start256 = v; key256 = key;       end
        endcase
    endtask

    function automatic logic [255:0] rand_key();
        return {$urandom(), $urandom(), $urandom(), $urandom(),
                $urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Runs one expansion; optional re-pulse of start with alt_key, optional reset after edge T+rst_at.
    task automatic run_expansion(input int nk, input logic [255:0] key, input int repulse_at,
                                 input logic [255:0] alt_key, input int rst_at);
        int nr = nk + 6;
        int exp_lat = 4 * (nr + 1) - nk + 1;
        int cyc = 0;
        bit seen = 1'b0;
        ref_expand(nk, key);
        @(negedge clk);
        drive_start(nk, 1'b1, key);
        @(posedge clk);
        @(negedge clk);
        drive_start(nk, 1'b0, ~key);
        check($sformatf("busy_after_start_nk%0d", nk), 128'(dut_busy(nk)), 128'd1);
        check($sformatf("kv_cleared_nk%0d", nk), 128'(dut_kv(nk)), 128'd0);
        while (!seen && cyc < 200) begin
            if (repulse_at > 0 && cyc == repulse_at - 1) drive_start(nk, 1'b1, alt_key);
            @(posedge clk);
            cyc++;
            if (rst_at > 0 && cyc == rst_at) begin
                #2 rst_n = 1'b0;
                #1;
                check($sformatf("rst_busy_nk%0d", nk), 128'(dut_busy(nk)), 128'd0);
                check($sformatf("rst_kv_nk%0d", nk), 128'(dut_kv(nk)), 128'd0);
                check($sformatf("rst_done_nk%0d", nk), 128'(dut_done(nk)), 128'd0);
                check($sformatf("rst_rk_nk%0d", nk), 128'(dut_any(nk)), 128'd0);
                return;
            end
            @(negedge clk);
            if (repulse_at > 0 && cyc == repulse_at) drive_start(nk, 1'b0, ~alt_key);
            if (dut_done(nk)) seen = 1'b1;
        end
        check($sformatf("done_latency_nk%0d", nk), 128'(cyc), 128'(exp_lat));
        check($sformatf("kv_at_done_nk%0d", nk), 128'(dut_kv(nk)), 128'd1);
        check($sformatf("busy_at_done_nk%0d", nk), 128'(dut_busy(nk)), 128'd0);
        for (int r = 0; r <= nr; r++) begin
            check($sformatf("round%0d_nk%0d", r, nk), dut_round(nk, r),
                  {mw[4*r], mw[4*r+1], mw[4*r+2], mw[4*r+3]});
        end
        @(negedge clk);
        check($sformatf("done_pulse_nk%0d", nk), 128'(dut_done(nk)), 128'd0);
        check($sformatf("kv_holds_nk%0d", nk), 128'(dut_kv(nk)), 128'd1);
    endtask

    initial begin
        logic [255:0] k, k2;
        logic [127:0] r_tmp;

        for (int a = 0; a < 256; a++) ref_tab[a] = sbox_def(8'(a));

        repeat (2) @(negedge clk);
        for (int nk = 4; nk <= 8; nk += 2) begin
            check($sformatf("reset_busy_nk%0d", nk), 128'(dut_busy(nk)), 128'd0);
            check($sformatf("reset_done_nk%0d", nk), 128'(dut_done(nk)), 128'd0);
            check($sformatf("reset_kv_nk%0d", nk), 128'(dut_kv(nk)), 128'd0);
            check($sformatf("reset_rk_nk%0d", nk), 128'(dut_any(nk)), 128'd0);
        end
        rst_n = 1'b1;

        // FIPS-197 vectors
        k = {128'h0, 128'h2b7e151628aed2a6abf7158809cf4f3c};
        run_expansion(4, k, 0, '0, 0);
        check("fips128_round1", dut_round(4, 1), 128'ha0fafe1788542cb123a339392a6c7605);
        check("fips128_round10", dut_round(4, 10), 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

        k = {64'h0, 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b};
        run_expansion(6, k, 0, '0, 0);
        r_tmp = dut_round(6, 12);
        check("fips192_w51", 128'(r_tmp[31:0]), 128'h01002202);

        k = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
        run_expansion(8, k, 0, '0, 0);
        r_tmp = dut_round(8, 14);
        check("fips256_w59", 128'(r_tmp[31:0]), 128'h706c631e);

        // random keys, back-to-back from DONE
        for (int it = 0; it < 3; it++) begin
            for (int nk = 4; nk <= 8; nk += 2) run_expansion(nk, rand_key(), 0, '0, 0);
        end

        // start re-pulsed mid-expansion is ignored
        k  = rand_key();
        k2 = rand_key();
        run_expansion(4, k, 10, k2, 0);

        // asynchronous reset mid-expansion, then a fresh run
        run_expansion(4, rand_key(), 0, '0, 20);
        @(negedge clk);
        rst_n = 1'b1;
        run_expansion(4, rand_key(), 0, '0, 0);
        run_expansion(8, rand_key(), 0, '0, 0);

`ifdef AES_KEYEXP_ZEROIZE_EN
        run_expansion(4, rand_key(), 0, '0, 0);
        zeroize128 = 1'b1;
        @(negedge clk);
        zeroize128 = 1'b0;
        check("zeroize_rk", 128'(|rk128), 128'd0);
        check("zeroize_kv", 128'(kv128), 128'd0);
        check("zeroize_busy", 128'(busy128), 128'd0);
        @(negedge clk);
        check("zeroize_idle", 128'(busy128), 128'd0);
        run_expansion(4, rand_key(), 0, '0, 0);
        zeroize128 = 1'b1;
        drive_start(4, 1'b1, rand_key());
        @(negedge clk);
        zeroize128 = 1'b0;
        drive_start(4, 1'b0, '0);
        check("zeroize_wins_busy", 128'(busy128), 128'd0);
        check("zeroize_wins_kv", 128'(kv128), 128'd0);
        check("zeroize_wins_rk", 128'(|rk128), 128'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
